// File: rtl/grant_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : grant_burst_ctrl_if
// Purpose  : Bundles the arbiter grant, the four requester beat channels, the
//            shared sink channel and the status strobes of grant_burst_ctrl.
// Signals  : GRANT_I    one-hot grant from arbiter (bit3 = user 1 .. bit0 = user 4)
//            src_data   packed requester data, slice k = [DATA_W*k +: DATA_W]
//            src_valid  per-requester beat valid
//            src_ready  per-requester ready (owner bit only)
//            out_data / out_valid / out_ready / out_last   sink channel
//            out_owner  index of current owner (0 when idle)
//            done       one-cycle completion strobe per requester
//            err_onehot / err_timeout   one-cycle error strobes
// Modports : slave  - the controller
//            master - the environment (arbiter, requesters, sink)
// Revision : 1.0  initial release
// ============================================================================
interface grant_burst_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          GRANT_I;
    logic [4*DATA_W-1:0] src_data;
    logic [3:0]          src_valid;
    logic [3:0]          src_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [1:0]          out_owner;
    logic [3:0]          done;
    logic                err_onehot;
    logic                err_timeout;

    modport slave (
        input  GRANT_I, src_data, src_valid, out_ready,
        output src_ready, out_data, out_valid, out_last, out_owner,
               done, err_onehot, err_timeout
    );

    modport master (
        output GRANT_I, src_data, src_valid, out_ready,
        input  src_ready, out_data, out_valid, out_last, out_owner,
               done, err_onehot, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/grant_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : grant_burst_ctrl
// Purpose  : Latches the one-hot arbiter grant as bus owner, moves BURST_LEN
//            beats from that requester to the shared sink over valid/ready,
//            then strobes done[k] so the requester can drop its request.
// Ports    : clk    - clock, all state on posedge
//            rst_n  - asynchronous active-low reset
//            bus    - grant_burst_ctrl_if.slave (grant, source, sink, status)
// Params   : DATA_W    beat width
//            BURST_LEN beats per grant (1..255)
//            TIMEOUT   stall cycles before abort (1..255)
// Option   : GRANT_BURST_TIMEOUT_EN - compiles in the stall counter and the
//            timeout abort path; otherwise err_timeout is tied low.
// Revision : 1.0  initial release
// ============================================================================
module grant_burst_ctrl #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    grant_burst_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] C_LAST_IDX = 8'(BURST_LEN - 1);

    logic [1:0] r_state;
    logic [1:0] r_owner;
    logic [7:0] r_beat_cnt;
    logic       r_guard_valid;
    logic [1:0] r_guard_owner;
    logic [3:0] r_done;
    logic       r_err_onehot;

    logic [3:0]        w_grant;
    logic              w_onehot;
    logic              w_multi;
    logic [1:0]        w_grant_idx;
    logic [3:0]        w_guard_code;
    logic              w_blocked;
    logic              w_xfer;
    logic              w_src_valid_k;
    logic              w_beat;
    logic              w_last_idx;
    logic [DATA_W-1:0] w_slice [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign w_slice[gi] = bus.src_data[DATA_W*gi +: DATA_W];
    end

    assign w_grant  = bus.GRANT_I;
    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    assign w_onehot = (w_grant != 4'd0) && ((w_grant & (w_grant - 4'd1)) == 4'd0);
    assign w_multi  = (w_grant != 4'd0) && !w_onehot;

    always_comb begin
        w_grant_idx = 2'd0;
        if (w_grant[3])      w_grant_idx = 2'd3;
        else if (w_grant[2]) w_grant_idx = 2'd2;
        else if (w_grant[1]) w_grant_idx = 2'd1;
    end

    // The arbiter keeps its grant up for a few cycles after done; without this
    // guard the same owner would immediately be granted a second burst.
    assign w_guard_code = 4'b0001 << r_guard_owner;
    assign w_blocked    = r_guard_valid && (w_grant == w_guard_code);

    assign w_xfer        = (r_state == S_XFER);
    assign w_src_valid_k = bus.src_valid[r_owner];
    assign w_beat        = w_xfer && w_src_valid_k && bus.out_ready;
    assign w_last_idx    = (r_beat_cnt == C_LAST_IDX);

    // Sink channel is a combinational pass-through of the registered owner.
    assign bus.out_valid  = w_xfer && w_src_valid_k;
    assign bus.out_data   = w_xfer ? w_slice[r_owner] : '0;
    assign bus.out_last   = w_xfer && w_src_valid_k && w_last_idx;
    assign bus.src_ready  = w_xfer ? ({3'b000, bus.out_ready} << r_owner) : 4'b0000;
    assign bus.out_owner  = (r_state == S_IDLE) ? 2'd0 : r_owner;
    assign bus.done       = r_done;
    assign bus.err_onehot = r_err_onehot;

`ifdef GRANT_BURST_TIMEOUT_EN
    localparam logic [7:0] C_STALL_LIM = 8'(TIMEOUT - 1);
    logic [7:0] r_stall_cnt;
    logic       r_err_timeout;
    assign bus.err_timeout = r_err_timeout;
`else
    assign bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_owner       <= 2'd0;
            r_beat_cnt    <= 8'd0;
            r_guard_valid <= 1'b0;
            r_guard_owner <= 2'd0;
            r_done        <= 4'd0;
            r_err_onehot  <= 1'b0;
`ifdef GRANT_BURST_TIMEOUT_EN
            r_stall_cnt   <= 8'd0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_done       <= 4'd0;
            r_err_onehot <= 1'b0;
`ifdef GRANT_BURST_TIMEOUT_EN
            r_err_timeout <= 1'b0;
`endif
            // Any grant other than the blocked owner's code releases the guard.
            // Arming below (later in this block) takes priority.
            if (r_guard_valid && (w_grant != w_guard_code))
                r_guard_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_onehot && !w_blocked) begin
                        r_owner    <= w_grant_idx;
                        r_beat_cnt <= 8'd0;
`ifdef GRANT_BURST_TIMEOUT_EN
                        r_stall_cnt <= 8'd0;
`endif
                        r_state    <= S_XFER;
                    end else if (w_multi) begin
                        r_err_onehot <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_beat) begin
`ifdef GRANT_BURST_TIMEOUT_EN
                        r_stall_cnt <= 8'd0;
`endif
                        if (w_last_idx) begin
                            r_state       <= S_DONE;
                            r_done        <= 4'b0001 << r_owner;
                            r_guard_valid <= 1'b1;
                            r_guard_owner <= r_owner;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
`ifdef GRANT_BURST_TIMEOUT_EN
                    // This stall cycle brings the count to TIMEOUT: abort.
                    else if (r_stall_cnt == C_STALL_LIM) begin
                        r_stall_cnt   <= 8'd0;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                        r_guard_valid <= 1'b1;
                        r_guard_owner <= r_owner;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grant_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_grant_burst_ctrl
// Purpose  : Scoreboard bench for grant_burst_ctrl. Stimulus pushes expected
//            beats, done strobes and error strobes into queues; a monitor on
//            the falling edge pops and compares whenever the DUT presents one.
// Revision : 1.0  initial release
// ============================================================================
module tb_grant_burst_ctrl;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 15;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] owner;
    } beat_t;

    logic clk;
    logic rst_n;

    grant_burst_ctrl_if #(.DATA_W(DATA_W)) bus ();

    grant_burst_ctrl #(
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t      exp_beats[$];
    logic [3:0] exp_done[$];
    bit         exp_oh[$];
    bit         exp_tmo[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s unexpected event at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int k, input logic [7:0] base, input int first, input int upto);
        beat_t b;
        for (int i = first; i < upto; i++) begin
            b.data  = base + 8'(i);
            b.last  = (i == BURST_LEN - 1);
            b.owner = 2'(k);
            exp_beats.push_back(b);
        end
    endtask

    // Requester + sink model: presents beat idx of requester k until it is
    // handshaken, with out_ready following rpat[cycle % 4].
    task automatic do_burst(input int k, input logic [7:0] base, input int first,
                            input int upto, input logic [3:0] rpat, output int ncyc);
        int   idx;
        int   n;
        logic hs;
        idx = first;
        n   = 0;
        while (idx < upto && n < 60) begin
            bus.out_ready = rpat[n % 4];
            bus.src_valid = 4'b0001 << k;
            bus.src_data[8*k +: 8] = base + 8'(idx);
            @(negedge clk);
            hs = bus.out_valid && bus.out_ready;
            step();
            n++;
            if (hs) idx++;
        end
        bus.src_valid = 4'b0000;
        if (idx < upto) chk("burst_budget", 32'(idx), 32'(upto));
        ncyc = n;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_beats.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    chk("beat_data",  32'(bus.out_data),  32'(e.data));
                    chk("beat_last",  32'(bus.out_last),  32'(e.last));
                    chk("beat_owner", 32'(bus.out_owner), 32'(e.owner));
                    chk("beat_src_ready", 32'(bus.src_ready), 32'(4'b0001 << e.owner));
                end
            end else if (bus.out_valid) begin
                chk("stall_src_ready", 32'(bus.src_ready), 32'd0);
                if (exp_beats.size() != 0)
                    chk("stall_data_hold", 32'(bus.out_data), 32'(exp_beats[0].data));
            end
            if (bus.done != 4'd0) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else chk("done_code", 32'(bus.done), 32'(exp_done.pop_front()));
            end
            if (bus.err_onehot) begin
                if (exp_oh.size() == 0) fail_now("unexpected_err_onehot");
                else void'(exp_oh.pop_front());
            end
            if (bus.err_timeout) begin
                if (exp_tmo.size() == 0) fail_now("unexpected_err_timeout");
                else void'(exp_tmo.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        rst_n         = 1'b0;
        bus.GRANT_I   = 4'd0;
        bus.src_data  = '0;
        bus.src_valid = 4'd0;
        bus.out_ready = 1'b0;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_owner", 32'(bus.out_owner), 32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_errs",      32'({bus.err_onehot, bus.err_timeout}), 32'd0);
        rst_n = 1'b1;
        step();

        // ---- basic burst, user 2 (bit 2)
        bus.GRANT_I = 4'b0100;
        bus.out_ready = 1'b1;
        push_burst(2, 8'h11, 0, BURST_LEN);
        exp_done.push_back(4'b0100);
        step();
        bus.GRANT_I = 4'b0000;
        chk("basic_owner", 32'(bus.out_owner), 32'd2);
        do_burst(2, 8'h11, 0, BURST_LEN, 4'b1111, n);
        chk("basic_cycles", 32'(n), 32'(BURST_LEN));
        chk("done_state_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("basic_idle_owner", 32'(bus.out_owner), 32'd0);

        // ---- backpressure 1,0,1,0
        bus.GRANT_I = 4'b0100;
        push_burst(2, 8'h61, 0, BURST_LEN);
        exp_done.push_back(4'b0100);
        step();
        bus.GRANT_I = 4'b0000;
        do_burst(2, 8'h61, 0, BURST_LEN, 4'b0101, n);
        chk("bp_cycles", 32'(n), 32'(2*BURST_LEN - 1));
        step();

        // ---- held grant must not restart a burst
        bus.GRANT_I = 4'b1000;
        push_burst(3, 8'h21, 0, BURST_LEN);
        exp_done.push_back(4'b1000);
        step();
        chk("held_owner", 32'(bus.out_owner), 32'd3);
        do_burst(3, 8'h21, 0, BURST_LEN, 4'b1111, n);
        chk("held_cycles", 32'(n), 32'(BURST_LEN));
        bus.src_valid = 4'b1000;
        bus.out_ready = 1'b1;
        bus.src_data[31:24] = 8'hEE;
        repeat (10) step();
        chk("held_blocked_owner", 32'(bus.out_owner), 32'd0);
        chk("held_blocked_ready", 32'(bus.src_ready), 32'd0);
        bus.src_valid = 4'b0000;
        bus.GRANT_I = 4'b0000;
        step();
        bus.GRANT_I = 4'b1000;
        push_burst(3, 8'h71, 0, BURST_LEN);
        exp_done.push_back(4'b1000);
        step();
        chk("regrant_owner", 32'(bus.out_owner), 32'd3);
        do_burst(3, 8'h71, 0, BURST_LEN, 4'b1111, n);
        // in DONE: arbiter moves to user 4
        bus.GRANT_I   = 4'b0001;
        bus.src_valid = 4'b0001;
        bus.out_ready = 1'b1;
        bus.src_data[7:0] = 8'h31;
        push_burst(0, 8'h31, 0, BURST_LEN);
        exp_done.push_back(4'b0001);
        step();
        chk("u4_idle_ready", 32'(bus.src_ready), 32'd0);
        step();
        chk("u4_start_ready", 32'(bus.src_ready), 32'd1);
        bus.GRANT_I = 4'b0000;
        do_burst(0, 8'h31, 0, BURST_LEN, 4'b1111, n);
        chk("u4_cycles", 32'(n), 32'(BURST_LEN));
        step();

        // ---- illegal grant
        bus.GRANT_I   = 4'b0110;
        bus.src_valid = 4'b0110;
        bus.out_ready = 1'b1;
        exp_oh.push_back(1'b1);
        step();
        bus.GRANT_I = 4'b0000;
        chk("illegal_src_ready", 32'(bus.src_ready), 32'd0);
        chk("illegal_out_valid", 32'(bus.out_valid), 32'd0);
        chk("illegal_err_pulse", 32'(bus.err_onehot), 32'd1);
        bus.src_valid = 4'b0000;
        step();
        chk("illegal_err_clear", 32'(bus.err_onehot), 32'd0);

        // ---- stall after 2 beats
        bus.GRANT_I = 4'b0100;
        push_burst(2, 8'h81, 0, 2);
        step();
        bus.GRANT_I = 4'b0000;
        do_burst(2, 8'h81, 0, 2, 4'b1111, n);
        bus.out_ready = 1'b1;
`ifdef GRANT_BURST_TIMEOUT_EN
        exp_tmo.push_back(1'b1);
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            if (bus.err_timeout) break;
            step();
            c++;
        end
        chk("timeout_latency", 32'(c), 32'(TIMEOUT));
        step();
        chk("timeout_idle_owner", 32'(bus.out_owner), 32'd0);
        chk("timeout_err_clear", 32'(bus.err_timeout), 32'd0);
`else
        c = 0;
        repeat (40) step();
        chk("no_timeout_owner", 32'(bus.out_owner), 32'd2);
        chk("no_timeout_err", 32'(bus.err_timeout), 32'd0);
        push_burst(2, 8'h81, 2, BURST_LEN);
        exp_done.push_back(4'b0100);
        do_burst(2, 8'h81, 2, BURST_LEN, 4'b1111, n);
        chk("finish_cycles", 32'(n), 32'(BURST_LEN - 2));
        step();
`endif
        step();

        // ---- reset mid-burst
        bus.GRANT_I = 4'b0010;
        push_burst(1, 8'h41, 0, 2);
        step();
        bus.GRANT_I = 4'b0000;
        do_burst(1, 8'h41, 0, 2, 4'b1111, n);
        bus.src_valid = 4'b0010;
        bus.src_data[15:8] = 8'h43;
        bus.out_ready = 1'b1;
        #1;
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.src_ready), 32'd0);
        chk("mid_rst_owner", 32'(bus.out_owner), 32'd0);
        chk("mid_rst_done",  32'(bus.done),      32'd0);
        bus.src_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        bus.GRANT_I = 4'b0010;
        push_burst(1, 8'h51, 0, BURST_LEN);
        exp_done.push_back(4'b0010);
        step();
        bus.GRANT_I = 4'b0000;
        do_burst(1, 8'h51, 0, BURST_LEN, 4'b1111, n);
        chk("post_rst_cycles", 32'(n), 32'(BURST_LEN));
        repeat (3) step();

        chk("left_beats", 32'(exp_beats.size()), 32'd0);
        chk("left_done",  32'(exp_done.size()),  32'd0);
        chk("left_oh",    32'(exp_oh.size()),    32'd0);
        chk("left_tmo",   32'(exp_tmo.size()),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
